matmul_seq_accel: RTL and testbench

Sequential, parametrised successor to the combinational vector-matrix accelerator on the CPU's native memory bus. It computes the row vector A (length R) times matrix B (R×S) into S accumulators using LANES multiply-accumulate units that are time-multiplexed over columns. A control/status register starts a run, selects accumulate mode and reports busy/done/error. The block sits as a memory-mapped peripheral beside the CPU, in the same address window as its predecessor.

---
 rtl/matmul_seq_accel.sv | 223 ++++++++++++++++++++++
 tb/tb_matmul_seq_accel.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_accel.sv
// Memory-mapped sequential vector x matrix accelerator: A (R) times B (RxS) into S
// accumulators using LANES time-multiplexed MAC units. Define MATMUL_SAT_EN for saturating sums.
module matmul_seq_accel #(
   parameter logic [31:0] ADDR_BASE    = 32'h0110_0000,
   parameter int          R            = 8,
   parameter int          S            = 4,
   parameter int          LANES        = 2,
   parameter int          INPUT_WIDTH  = 8,
   parameter int          RESULT_WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata
);

   localparam int G  = S / LANES;
   localparam int IW = INPUT_WIDTH;
   localparam int RW = RESULT_WIDTH;
   localparam int AW = (R > 1) ? $clog2(R) : 1;
   localparam int BW = (R * S > 1) ? $clog2(R * S) : 1;
   localparam int SW = (S > 1) ? $clog2(S) : 1;
   localparam int GW = (G > 1) ? $clog2(G) : 1;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   r_q;
   logic [GW-1:0]   g_q;
   logic [IW-1:0]   a_mem [R];
   logic [IW-1:0]   b_mem [R*S];
   logic [RW-1:0]   acc_q [S];
   logic            done_q, werr_q, ovf_bit;

   // ---------------- bus decode ----------------
   logic [31:0] offset;
   logic [9:0]  word;
   logic [1:0]  region;
   logic        in_win, accept, is_wr, busy;
   logic        a_hit, b_hit, s_hit, is_ctrl;
   logic        wr_a, wr_b, busy_wr_err, start_ok;
   logic [1:0]  ctrl_bits;

   assign offset    = mem_addr - ADDR_BASE;
   assign in_win    = (mem_addr >= ADDR_BASE) && (offset < 32'h4000);
   assign accept    = mem_valid && in_win && !mem_ready;
   assign is_wr     = |mem_wstrb;
   assign region    = offset[13:12];
   assign word      = offset[11:2];
   assign busy      = (state_q != IDLE);

   assign a_hit     = (region == 2'd0) && (32'(word) < 32'(R));
   assign b_hit     = (region == 2'd1) && (32'(word) < 32'(R * S));
   assign s_hit     = (region == 2'd2) && (32'(word) < 32'(S));
   assign is_ctrl   = (region == 2'd3) && (word == 10'd0);
   assign ctrl_bits = mem_wstrb[0] ? mem_wdata[1:0] : 2'b00;

   assign wr_a        = accept && is_wr && a_hit && !busy;
   assign wr_b        = accept && is_wr && b_hit && !busy;
   // While a run owns the datapath, configuration writes lose and are flagged.
   assign busy_wr_err = accept && is_wr && busy && (a_hit || b_hit || is_ctrl);
   assign start_ok    = accept && is_wr && is_ctrl && ctrl_bits[0] && !busy;

   function automatic logic [IW-1:0] merge_lanes(input logic [IW-1:0] old,
                                                 input logic [31:0]   wdata,
                                                 input logic [3:0]    wstrb);
      logic [31:0] w;
      w = 32'(old);
      for (int b = 0; b < 4; b++)
         if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      return IW'(w);
   endfunction

   // ---------------- control FSM ----------------
   logic clear_acc, run_en, last_step;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before the edge, independent of statement order.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value held,
      // which would otherwise infer a latch.
      state_d   = state_q;
      clear_acc = 1'b0;
      run_en    = 1'b0;
      last_step = 1'b0;
      case (state_q)
         IDLE:  if (start_ok) state_d = ctrl_bits[1] ? RUN : CLEAR;
         CLEAR: begin
            clear_acc = 1'b1;
            state_d   = RUN;
         end
         RUN: begin
            run_en = 1'b1;
            if (g_q == GW'(G - 1) && r_q == AW'(R - 1)) begin
               last_step = 1'b1;
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Inner counter r walks rows; outer counter g selects the group of LANES columns.
   always_ff @(posedge clk) begin
      if (reset || start_ok) begin
         r_q <= '0;
         g_q <= '0;
      end else if (run_en) begin
         if (r_q == AW'(R - 1)) begin
            r_q <= '0;
            g_q <= last_step ? '0 : g_q + 1'b1;
         end else begin
            r_q <= r_q + 1'b1;
         end
      end
   end

   // ---------------- MAC lanes ----------------
   logic [SW-1:0] col      [LANES];
   logic [RW-1:0] acc_next [LANES];
`ifdef MATMUL_SAT_EN
   logic [LANES-1:0] lane_ovf;
`endif

   always_comb begin
      logic [BW-1:0] bidx;
      logic [RW-1:0] prod;
`ifdef MATMUL_SAT_EN
      logic [RW:0]   wide;
      lane_ovf = '0;
`endif
      for (int l = 0; l < LANES; l++) begin
         col[l]      = SW'(int'(g_q) * LANES + l);
         bidx        = BW'(int'(col[l]) * R + int'(r_q));
         prod        = RW'(a_mem[r_q]) * RW'(b_mem[bidx]);
`ifdef MATMUL_SAT_EN
         wide        = {1'b0, acc_q[col[l]]} + {1'b0, prod};
         lane_ovf[l] = wide[RW];
         acc_next[l] = wide[RW] ? '1 : wide[RW-1:0];
`else
         acc_next[l] = acc_q[col[l]] + prod;
`endif
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: these arrays are small register files, not RAM macros, so they are
      // reset explicitly; a reset mid-run must leave every accumulator at zero.
      if (reset || clear_acc) begin
         for (int c = 0; c < S; c++) acc_q[c] <= '0;
      end else if (run_en) begin
         for (int l = 0; l < LANES; l++) acc_q[col[l]] <= acc_next[l];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < R; i++)     a_mem[i] <= '0;
         for (int i = 0; i < R * S; i++) b_mem[i] <= '0;
      end else begin
         if (wr_a) a_mem[word[AW-1:0]] <= merge_lanes(a_mem[word[AW-1:0]], mem_wdata, mem_wstrb);
         if (wr_b) b_mem[word[BW-1:0]] <= merge_lanes(b_mem[word[BW-1:0]], mem_wdata, mem_wstrb);
      end
   end

   // ---------------- sticky status flags ----------------
   always_ff @(posedge clk) begin
      if (reset || start_ok) begin
         done_q <= 1'b0;
         werr_q <= 1'b0;
      end else begin
         if (state_q == DONE) done_q <= 1'b1;
         if (busy_wr_err)     werr_q <= 1'b1;
      end
   end

`ifdef MATMUL_SAT_EN
   logic ovf_q;
   always_ff @(posedge clk) begin
      if (reset || start_ok)      ovf_q <= 1'b0;
      else if (run_en && |lane_ovf) ovf_q <= 1'b1;
   end
   assign ovf_bit = ovf_q;
`else
   assign ovf_bit = 1'b0;
`endif

   // ---------------- read path ----------------
   logic [31:0] rd_val;

   always_comb begin
      rd_val = '0;
      case (region)
         2'd0: if (a_hit)   rd_val = 32'(a_mem[word[AW-1:0]]);
         2'd1: if (b_hit)   rd_val = 32'(b_mem[word[BW-1:0]]);
         2'd2: if (s_hit)   rd_val = 32'(acc_q[word[SW-1:0]]);
         2'd3: if (is_ctrl) rd_val = {28'b0, ovf_bit, werr_q, done_q, busy};
         default: rd_val = '0;
      endcase
   end

   // Acknowledge is a single-cycle pulse; a held request is re-sampled once it drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_ready <= accept;
         mem_rdata <= (accept && !is_wr) ? rd_val : '0;
      end
   end

endmodule

// File: tb/tb_matmul_seq_accel.sv
// Self-checking bench for matmul_seq_accel: directed bus/timing steps plus random runs
// against an arithmetic reference model; a second 16-bit-result instance covers wrap/saturation.
module tb_matmul_seq_accel;

   localparam int R       = 8;
   localparam int S       = 4;
   localparam int LANES   = 2;
   localparam int IW      = 8;
   localparam int RUN_CYC = R * S / LANES;
   localparam logic [31:0] BASE0 = 32'h0110_0000;
   localparam logic [31:0] BASE1 = 32'h0220_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        ready0, ready1;
   logic [31:0] rdata0, rdata1;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   matmul_seq_accel #(.ADDR_BASE(BASE0), .R(R), .S(S), .LANES(LANES),
                      .INPUT_WIDTH(IW), .RESULT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(ready0),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(rdata0));

   matmul_seq_accel #(.ADDR_BASE(BASE1), .R(R), .S(S), .LANES(LANES),
                      .INPUT_WIDTH(IW), .RESULT_WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(ready1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(rdata1));

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: index 0 is the 32-bit instance, index 1 the 16-bit one.
   longint unsigned a_m   [2][R];
   longint unsigned b_m   [2][R*S];
   longint unsigned res_m [2][S];
   bit              ovf_m [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] base_of(input int d);
      return (d != 0) ? BASE1 : BASE0;
   endfunction

   function automatic longint unsigned merge_m(input longint unsigned old,
                                               input logic [31:0] wd, input logic [3:0] st);
      logic [31:0] w;
      w = 32'(old);
      for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
      return longint'(w & 32'h0000_00FF);
   endfunction

   // Result column c = sum over rows of A[r]*B(r,c), wrapped or clamped at the result width.
   task automatic model_run(input int d, input bit accum);
      longint unsigned one = 1;
      longint unsigned lim, acc, p;
      lim = (one << ((d != 0) ? 16 : 32)) - 1;
      ovf_m[d] = 1'b0;
      for (int c = 0; c < S; c++) begin
         acc = accum ? res_m[d][c] : 0;
         for (int r = 0; r < R; r++) begin
            p = a_m[d][r] * b_m[d][c*R + r];
`ifdef MATMUL_SAT_EN
            if (acc + p > lim) begin
               acc      = lim;
               ovf_m[d] = 1'b1;
            end else begin
               acc = acc + p;
            end
`else
            acc = (acc + p) & lim;
`endif
         end
         res_m[d][c] = acc;
      end
   endtask

   // One bus transaction, entered and left on a falling edge. edge_no is the cycle
   // count of the rising edge that accepted the request.
   task automatic bus(input int d, input logic [31:0] off, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rdata, output int edge_no);
      bit seen;
      seen      = 1'b0;
      rdata     = '0;
      edge_no   = -1;
      mem_addr  = base_of(d) + off;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      mem_valid = 1'b1;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clk);
         if (((d != 0) ? ready1 : ready0) === 1'b1) begin
            seen    = 1'b1;
            edge_no = cyc;
            rdata   = (d != 0) ? rdata1 : rdata0;
         end
      end
      mem_valid = 1'b0;
      mem_wstrb = '0;
      check($sformatf("ack d%0d off %h", d, off), 32'(seen), 32'd1);
   endtask

   task automatic wr(input int d, input logic [31:0] off, input logic [31:0] wdata,
                     input logic [3:0] wstrb);
      logic [31:0] v;
      int e;
      bus(d, off, wdata, wstrb, v, e);
   endtask

   task automatic rd(input int d, input logic [31:0] off, output logic [31:0] v);
      int e;
      bus(d, off, 32'h0, 4'h0, v, e);
   endtask

   task automatic set_a(input int d, input int i, input logic [31:0] wdata, input logic [3:0] wstrb);
      wr(d, 32'(4 * i), wdata, wstrb);
      a_m[d][i] = merge_m(a_m[d][i], wdata, wstrb);
   endtask

   task automatic set_b(input int d, input int r, input int c, input logic [31:0] wdata);
      wr(d, 32'h1000 + 32'(4 * (c*R + r)), wdata, 4'hF);
      b_m[d][c*R + r] = merge_m(b_m[d][c*R + r], wdata, 4'hF);
   endtask

   task automatic start_run(input int d, input bit accum, output int start_edge);
      logic [31:0] v;
      bus(d, 32'h3000, accum ? 32'h3 : 32'h1, 4'hF, v, start_edge);
      model_run(d, accum);
   endtask

   // Poll STATUS: BUSY must hold for exactly run_len cycles after the START edge.
   task automatic wait_done(input int d, input int start_edge, input int run_len);
      logic [31:0] st;
      int e, k;
      bit finished;
      finished = 1'b0;
      for (int n = 0; n < 40 && !finished; n++) begin
         bus(d, 32'h3000, 32'h0, 4'h0, st, e);
         k = e - start_edge;
         check($sformatf("busy d%0d k=%0d", d, k), 32'(st[0]), 32'(k <= run_len));
         check($sformatf("done d%0d k=%0d", d, k), 32'(st[1]), 32'(k > run_len));
         if (k > run_len) finished = 1'b1;
      end
      check("run finished", 32'(finished), 32'd1);
   endtask

   task automatic check_results(input int d);
      logic [31:0] v;
      for (int c = 0; c < S; c++) begin
         rd(d, 32'h2000 + 32'(4 * c), v);
         check($sformatf("result d%0d[%0d]", d, c), v, 32'(res_m[d][c]));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: summary not reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      logic [3:0]  pat;
      int se;

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < R; i++)     a_m[d][i] = 0;
         for (int i = 0; i < R * S; i++) b_m[d][i] = 0;
         for (int i = 0; i < S; i++)     res_m[d][i] = 0;
         ovf_m[d] = 1'b0;
      end

      // Reset state
      reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
      repeat (2) @(negedge clk);
      check("reset ready", 32'({ready0, ready1}), 32'd0);
      check("reset rdata", rdata0, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      rd(0, 32'h3000, v); check("reset status", v, 32'd0);
      rd(0, 32'h2000, v); check("reset result0", v, 32'd0);
      rd(0, 32'h0000, v); check("reset A0", v, 32'd0);

      // Out-of-window read is never acknowledged
      mem_addr = BASE0 + 32'h4000; mem_wstrb = '0; mem_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("oow ready %0d", i), 32'(ready0), 32'd0);
      end
      mem_valid = 1'b0;
      @(negedge clk);

      // Held request on STATUS: acknowledge pattern 0,1,0,1 then 0 once released
      pat = 4'b1010;
      mem_addr = BASE0 + 32'h3000; mem_valid = 1'b1;
      check("held ready 0", 32'(ready0), 32'(pat[0]));
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("held ready %0d", i), 32'(ready0), 32'(pat[i]));
      end
      mem_valid = 1'b0;
      @(negedge clk);
      check("held ready release", 32'(ready0), 32'd0);

      // Load A = 1..8; B column 0 all ones, column c entries c
      for (int i = 0; i < R; i++) set_a(0, i, 32'(i + 1), 4'hF);
      for (int c = 0; c < S; c++)
         for (int r = 0; r < R; r++) set_b(0, r, c, (c == 0) ? 32'd1 : 32'(c));

      // Truncation and byte-lane merge on A[1]
      set_a(0, 1, 32'hFFFF_FF02, 4'hF);
      rd(0, 32'h4, v); check("A1 truncate", v, 32'(a_m[0][1]));
      set_a(0, 1, 32'h0000_00AB, 4'b0001);
      rd(0, 32'h4, v); check("A1 byte0", v, 32'h0000_00AB);
      set_a(0, 1, 32'h0000_CD00, 4'b0010);
      rd(0, 32'h4, v); check("A1 byte1", v, 32'(a_m[0][1]));
      set_a(0, 1, 32'd2, 4'hF);

      // Basic run: 1 + 16 + 1 cycles, results 36,36,72,108
      start_run(0, 1'b0, se);
      wait_done(0, se, RUN_CYC + 2);
      check_results(0);
      rd(0, 32'h3000, v); check("basic status", v, 32'h2);

      // Accumulate run: no CLEAR cycle, results doubled
      start_run(0, 1'b1, se);
      repeat (2) @(negedge clk);
      wait_done(0, se, RUN_CYC + 1);
      check_results(0);

      // Writes while busy: dropped, WERR set, second START ignored
      start_run(0, 1'b0, se);
      wr(0, 32'h0, 32'd9, 4'hF);
      wr(0, 32'h3000, 32'h1, 4'hF);
      wait_done(0, se, RUN_CYC + 2);
      rd(0, 32'h3000, v); check("busy-write status", v, 32'h6);
      rd(0, 32'h0, v);    check("busy-write A0", v, 32'(a_m[0][0]));
      check_results(0);

      // Random operands, both modes, both polling phases
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < R; i++) set_a(0, i, $urandom(), 4'hF);
         for (int c = 0; c < S; c++)
            for (int r = 0; r < R; r++) set_b(0, r, c, $urandom());
         start_run(0, bit'(it % 2), se);
         if (it < 2) repeat (2) @(negedge clk);
         wait_done(0, se, RUN_CYC + ((it % 2 == 1) ? 1 : 2));
         check_results(0);
         rd(0, 32'h3000, v); check($sformatf("random status %0d", it), v, 32'h2);
      end

      // Reset during RUN
      start_run(0, 1'b0, se);
      while (cyc < se + 5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrun ready", 32'(ready0), 32'd0);
      for (int i = 0; i < R; i++)     a_m[0][i] = 0;
      for (int i = 0; i < R * S; i++) b_m[0][i] = 0;
      for (int i = 0; i < S; i++)     res_m[0][i] = 0;
      rd(0, 32'h3000, v); check("midrun status", v, 32'd0);
      check_results(0);
      rd(0, 32'h0, v); check("midrun A0", v, 32'(a_m[0][0]));

      // 16-bit results with all operands 255: wrap to 61448 or clamp to 65535
      for (int i = 0; i < R; i++) set_a(1, i, 32'd255, 4'hF);
      for (int c = 0; c < S; c++)
         for (int r = 0; r < R; r++) set_b(1, r, c, 32'd255);
      start_run(1, 1'b0, se);
      wait_done(1, se, RUN_CYC + 2);
      check_results(1);
      rd(1, 32'h3000, v);
      check("narrow status", v, ovf_m[1] ? 32'hA : 32'h2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
